// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline stall/flush controller with memory-wait lock-up guard.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        do_hazard,
    input  logic        do_branch,
    input  logic        im_wait,
    input  logic        dm_wait,
    output logic        pc_write,
    output logic        reg1_write,
    output logic        reg2_write,
    output logic        reg3_write,
    output logic        reg4_write,
    output logic        reg1_flush,
    output logic        reg2_flush,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic        lockup
);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [8:0] C_WAIT_MAX = 9'(WAIT_MAX);

    state_t      state_q;
    logic [1:0]  init_cnt_q;
    logic        flush_pending_q;
    logic [7:0]  wait_cnt_q;
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;
    logic        lockup_q;

    logic        br_accept_w;
    logic        pend_clear_w;
    logic        any_wait_w;
    logic [8:0]  wait_next_w;

    assign any_wait_w  = im_wait | dm_wait;
    assign wait_next_w = {1'b0, wait_cnt_q} + 9'd1;

    always_comb begin
        pc_write     = 1'b0;
        reg1_write   = 1'b0;
        reg2_write   = 1'b0;
        reg3_write   = 1'b0;
        reg4_write   = 1'b0;
        reg1_flush   = 1'b0;
        reg2_flush   = 1'b0;
        br_accept_w  = 1'b0;
        pend_clear_w = 1'b0;
        case (state_q)
            S_INIT: begin
                reg1_flush = 1'b1;
                reg2_flush = 1'b1;
            end
            S_RUN: begin
                if (dm_wait) begin
                    // full freeze: branch/hazard are re-presented after release
                end else if (im_wait) begin
                    pc_write    = do_branch;
                    reg2_write  = 1'b1;
                    reg3_write  = 1'b1;
                    reg4_write  = 1'b1;
                    reg1_flush  = 1'b1;
                    reg2_flush  = do_branch | do_hazard;
                    br_accept_w = do_branch;
                end else begin
                    pend_clear_w = flush_pending_q;
                    if (do_branch) begin
                        pc_write    = 1'b1;
                        reg1_write  = 1'b1;
                        reg2_write  = 1'b1;
                        reg3_write  = 1'b1;
                        reg4_write  = 1'b1;
                        reg1_flush  = 1'b1;
                        reg2_flush  = 1'b1;
                        br_accept_w = 1'b1;
                    end else if (do_hazard) begin
                        reg2_write  = 1'b1;
                        reg3_write  = 1'b1;
                        reg4_write  = 1'b1;
                        reg2_flush  = 1'b1;
                    end else begin
                        pc_write    = 1'b1;
                        reg1_write  = 1'b1;
                        reg2_write  = 1'b1;
                        reg3_write  = 1'b1;
                        reg4_write  = 1'b1;
                    end
                    // kill the wrong-path instruction whose fetch just landed
                    if (flush_pending_q) begin
                        reg1_flush = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_INIT;
            init_cnt_q      <= 2'd0;
            flush_pending_q <= 1'b0;
            wait_cnt_q      <= 8'd0;
            stall_cnt_q     <= 16'd0;
            flush_cnt_q     <= 16'd0;
            lockup_q        <= 1'b0;
        end else begin
            case (state_q)
                S_INIT: begin
                    if (init_cnt_q == 2'd1) begin
                        state_q    <= S_RUN;
                        init_cnt_q <= 2'd0;
                    end else begin
                        init_cnt_q <= init_cnt_q + 2'd1;
                    end
                end
                S_RUN: begin
                    if (!pc_write && stall_cnt_q != 16'hFFFF) begin
                        stall_cnt_q <= stall_cnt_q + 16'd1;
                    end
                    if (br_accept_w && flush_cnt_q != 16'hFFFF) begin
                        flush_cnt_q <= flush_cnt_q + 16'd1;
                    end
                    if (br_accept_w && im_wait) begin
                        flush_pending_q <= 1'b1;
                    end else if (pend_clear_w) begin
                        flush_pending_q <= 1'b0;
                    end
                    if (any_wait_w) begin
                        wait_cnt_q <= wait_next_w[7:0];
                        if (wait_next_w >= C_WAIT_MAX) begin
                            lockup_q <= 1'b1;
                            state_q  <= S_HALT;
                        end
                    end else begin
                        wait_cnt_q <= 8'd0;
                    end
                end
                S_HALT: begin
                end
                default: begin
                    state_q <= S_INIT;
                end
            endcase
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign lockup    = lockup_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        do_hazard;
    logic        do_branch;
    logic        im_wait;
    logic        dm_wait;
    logic        pc_write;
    logic        reg1_write;
    logic        reg2_write;
    logic        reg3_write;
    logic        reg4_write;
    logic        reg1_flush;
    logic        reg2_flush;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic        lockup;

    int checks;
    int failures;

    // {pc, r1w, r2w, r3w, r4w, r1f, r2f}
    logic [6:0] ctl;
    assign ctl = {pc_write, reg1_write, reg2_write, reg3_write, reg4_write,
                  reg1_flush, reg2_flush};

    hazard_ctrl #(.WAIT_MAX(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .do_hazard  (do_hazard),
        .do_branch  (do_branch),
        .im_wait    (im_wait),
        .dm_wait    (dm_wait),
        .pc_write   (pc_write),
        .reg1_write (reg1_write),
        .reg2_write (reg2_write),
        .reg3_write (reg3_write),
        .reg4_write (reg4_write),
        .reg1_flush (reg1_flush),
        .reg2_flush (reg2_flush),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt),
        .lockup     (lockup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle, apply inputs just after the edge, settle at negedge.
    task automatic step(input logic h, input logic b, input logic iw, input logic dw);
        @(posedge clk);
        #1;
        do_hazard = h;
        do_branch = b;
        im_wait   = iw;
        dm_wait   = dw;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        do_hazard = 1'b0; do_branch = 1'b0; im_wait = 1'b0; dm_wait = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ctl !== 7'b0000011 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || lockup !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: ctl=%b stall=%h flush=%h lock=%b required ctl=0000011 0 0 0",
                     ctl, stall_cnt, flush_cnt, lockup);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ctl !== 7'b0000011) begin
            failures++;
            $display("FAIL init_cycle1: ctl=%b required 0000011", ctl);
        end
        step(0, 0, 0, 0);
        checks++;
        if (ctl !== 7'b0000011) begin
            failures++;
            $display("FAIL init_cycle2: ctl=%b required 0000011", ctl);
        end
        step(0, 0, 0, 0);
        checks++;
        if (ctl !== 7'b1111100) begin
            failures++;
            $display("FAIL run_cycle3: ctl=%b required 1111100", ctl);
        end
    endtask

    task automatic test_hazard;
        step(1, 0, 0, 0);
        checks++;
        if (ctl !== 7'b0011101 || stall_cnt !== 16'd0) begin
            failures++;
            $display("FAIL hazard_bubble: ctl=%b stall=%h required 0011101 0", ctl, stall_cnt);
        end
        step(0, 0, 0, 0);
        checks++;
        if (ctl !== 7'b1111100 || stall_cnt !== 16'd1) begin
            failures++;
            $display("FAIL hazard_after: ctl=%b stall=%h required 1111100 1", ctl, stall_cnt);
        end
    endtask

    task automatic test_branch_hazard;
        step(1, 1, 0, 0);
        checks++;
        if (ctl !== 7'b1111111) begin
            failures++;
            $display("FAIL branch_over_hazard: ctl=%b required 1111111", ctl);
        end
        step(0, 0, 0, 0);
        checks++;
        if (flush_cnt !== 16'd1 || stall_cnt !== 16'd1 || ctl !== 7'b1111100) begin
            failures++;
            $display("FAIL branch_counts: flush=%h stall=%h ctl=%b required 1 1 1111100",
                     flush_cnt, stall_cnt, ctl);
        end
    endtask

    task automatic test_im_wait_branch;
        step(0, 1, 1, 0);
        checks++;
        if (ctl !== 7'b1011111) begin
            failures++;
            $display("FAIL imwait_branch: ctl=%b required 1011111", ctl);
        end
        step(0, 0, 1, 0);
        checks++;
        if (ctl !== 7'b0011110) begin
            failures++;
            $display("FAIL imwait_c2: ctl=%b required 0011110", ctl);
        end
        step(0, 0, 1, 0);
        checks++;
        if (ctl !== 7'b0011110) begin
            failures++;
            $display("FAIL imwait_c3: ctl=%b required 0011110", ctl);
        end
        step(0, 0, 0, 0);
        checks++;
        if (ctl !== 7'b1111110) begin
            failures++;
            $display("FAIL pending_flush: ctl=%b required 1111110", ctl);
        end
        step(0, 0, 0, 0);
        checks++;
        if (ctl !== 7'b1111100 || flush_cnt !== 16'd2 || stall_cnt !== 16'd3) begin
            failures++;
            $display("FAIL pending_cleared: ctl=%b flush=%h stall=%h required 1111100 2 3",
                     ctl, flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_dm_priority;
        step(1, 1, 1, 1);
        checks++;
        if (ctl !== 7'b0000000) begin
            failures++;
            $display("FAIL dm_freeze: ctl=%b required 0000000", ctl);
        end
        step(0, 0, 0, 0);
        checks++;
        if (ctl !== 7'b1111100 || flush_cnt !== 16'd2 || stall_cnt !== 16'd4) begin
            failures++;
            $display("FAIL dm_release: ctl=%b flush=%h stall=%h required 1111100 2 4",
                     ctl, flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_lockup;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1);
            checks++;
            if (ctl !== 7'b0000000 || lockup !== 1'b0) begin
                failures++;
                $display("FAIL lock_freeze%0d: ctl=%b lock=%b required 0000000 0", i, ctl, lockup);
            end
        end
        step(0, 0, 0, 0);
        checks++;
        if (ctl !== 7'b0000000 || lockup !== 1'b1) begin
            failures++;
            $display("FAIL lock_halt: ctl=%b lock=%b required 0000000 1", ctl, lockup);
        end
        step(1, 1, 0, 0);
        checks++;
        if (ctl !== 7'b0000000 || lockup !== 1'b1 || stall_cnt !== 16'd8) begin
            failures++;
            $display("FAIL halt_ignores: ctl=%b lock=%b stall=%h required 0000000 1 8",
                     ctl, lockup, stall_cnt);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (ctl !== 7'b0000011 || lockup !== 1'b0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            failures++;
            $display("FAIL halt_reset: ctl=%b lock=%b stall=%h flush=%h required 0000011 0 0 0",
                     ctl, lockup, stall_cnt, flush_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        do_hazard = 1'b0; do_branch = 1'b0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        checks++;
        if (ctl !== 7'b1111100) begin
            failures++;
            $display("FAIL rerun: ctl=%b required 1111100", ctl);
        end
    endtask

    task automatic test_stall_saturation;
        for (int i = 0; i < 65534; i++) begin
            step(1, 0, 0, 0);
        end
        step(0, 0, 0, 0);
        checks++;
        if (stall_cnt !== 16'hFFFE) begin
            failures++;
            $display("FAIL stall_preload: stall=%h required fffe", stall_cnt);
        end
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        checks++;
        if (stall_cnt !== 16'hFFFF || ctl !== 7'b1111100) begin
            failures++;
            $display("FAIL stall_saturate: stall=%h ctl=%b required ffff 1111100", stall_cnt, ctl);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset;
        test_hazard;
        test_branch_hazard;
        test_im_wait_branch;
        test_dm_priority;
        test_lockup;
        test_stall_saturation;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
